// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: PC generator, single-outstanding imem request port and a
// DEPTH-entry prefetch FIFO feeding decode, with redirect flush and halt stop.
module fetch_prefetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFC000000
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_valid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  if_valid,
   output logic [DATA_WIDTH-1:0] if_instr,
   output logic [ADDR_WIDTH-1:0] if_pc_plus4,
   input  logic                  id_ready,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  halted
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic [ADDR_WIDTH-1:0] r_req_pc;
   logic                  r_outstanding;
   logic                  r_drop;
   logic                  r_halted;
   logic [CNT_W-1:0]      r_count;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [DATA_WIDTH-1:0] r_mem_instr [DEPTH];
   logic [ADDR_WIDTH-1:0] r_mem_pc4   [DEPTH];

   logic w_req;
   logic w_issue;
   logic w_resp;
   logic w_push;
   logic w_pop;

   // The count check already covers the in-flight request, so every response has a slot.
   assign w_req   = !r_halted && !r_outstanding && !redirect && (r_count < FULL);
   assign w_issue = w_req && imem_gnt;
   assign w_resp  = r_outstanding && imem_valid;
   assign w_push  = w_resp && !r_drop && !redirect;
   assign w_pop   = if_valid && id_ready && !redirect;

   assign imem_req    = w_req;
   assign imem_addr   = r_fetch_pc;
   assign halted      = r_halted;
   assign if_valid    = (r_count != '0);
   assign if_instr    = if_valid ? r_mem_instr[r_rd_ptr] : '0;
   assign if_pc_plus4 = if_valid ? r_mem_pc4[r_rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_instr[r_wr_ptr] <= imem_rdata;
         r_mem_pc4[r_wr_ptr]   <= r_req_pc + ADDR_WIDTH'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_req_pc      <= RESET_PC;
         r_outstanding <= 1'b0;
         r_drop        <= 1'b0;
         r_halted      <= 1'b0;
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
      end else if (redirect) begin
         // A still-pending response must be thrown away when it eventually lands.
         r_fetch_pc    <= redirect_pc;
         r_outstanding <= r_outstanding && !imem_valid;
         r_drop        <= r_outstanding && !imem_valid;
         r_halted      <= 1'b0;
         r_count       <= '0;
         r_rd_ptr      <= r_wr_ptr;
      end else begin
         if (w_issue) begin
            r_fetch_pc    <= r_fetch_pc + ADDR_WIDTH'(4);
            r_req_pc      <= r_fetch_pc;
            r_outstanding <= 1'b1;
         end
         if (w_resp) begin
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (imem_rdata == HALT_WORD) begin
               r_halted <= 1'b1;
            end
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(w_push && r_count == FULL));
   a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(w_pop && r_count == '0));

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised instruction-fetch stage for the next-generation pipelined MIPS core. It replaces the bare PC register plus IF/ID latch with a PC generator, a single-outstanding instruction-memory request port and a DEPTH-entry prefetch FIFO. It sits between instruction memory and the decode stage, absorbs decode stalls, flushes on branch/jump redirects and stops fetching after the halt word.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 32, PC / instruction address width
DEPTH, 4, prefetch FIFO entries; power of two, >= 2
RESET_PC, 0, PC loaded on reset
HALT_WORD, 32'hFC000000, encoding of the halt instruction

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  request valid to instruction memory
imem_addr  output  ADDR_WIDTH  request address (current fetch PC)
imem_gnt  input  1  memory accepts the request this cycle
imem_valid  input  1  response data valid
imem_rdata  input  DATA_WIDTH  response instruction word
if_valid  output  1  FIFO head valid to decode
if_instr  output  DATA_WIDTH  head instruction
if_pc_plus4  output  ADDR_WIDTH  head instruction address + 4
id_ready  input  1  decode consumes head this cycle
redirect  input  1  branch/jump taken; flush and refetch
redirect_pc  input  ADDR_WIDTH  new fetch PC
halted  output  1  halt word fetched; fetching stopped

Behaviour:
- Interface: one clock `clk`; `reset` synchronous, active-high.
- Reset values:
  - fetch_pc = RESET_PC.
  - count = 0; rd_ptr = wr_ptr = 0; outstanding = 0; drop = 0; halted = 0.
  - Outputs: if_valid = 0, imem_req = 0.
  - if_instr / if_pc_plus4 = 0.
  - Reset overrides every other input in the same cycle.
- Request issue:
  - imem_req = !halted && !outstanding && !redirect && (count < DEPTH).
  - imem_addr = fetch_pc.
  - Accept on imem_req && imem_gnt:
    - fetch_pc += 4, wrapping modulo 2^ADDR_WIDTH.
    - outstanding <= 1.
  - At most one request outstanding. Gating on count < DEPTH with outstanding folded in guarantees a free slot for every response.
- Response: imem_valid is ignored unless outstanding = 1. On a response, outstanding <= 0. Then:
  - If drop = 1: discard the data and clear drop.
  - Otherwise push {imem_rdata, address + 4} at wr_ptr. The pushed PC is taken from a per-request latched address, not from fetch_pc.
  - If imem_rdata == HALT_WORD: push it and set halted <= 1.
- Response latency: arbitrary, >= 1 cycle after grant. The same-cycle grant-and-valid case must not occur.
- Pop:
  - if_valid = (count != 0); head driven combinationally from rd_ptr.
  - Pop when if_valid && id_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits.
- Redirect has priority over push, pop and issue in the same cycle:
  - Flush: count <= 0, rd_ptr <= wr_ptr.
  - fetch_pc <= redirect_pc.
  - halted <= 0.
  - drop <= outstanding && !imem_valid. An in-flight response gets discarded; a response arriving in the redirect cycle is itself discarded.
  - imem_req is forced low that cycle. Issue from redirect_pc starts the next cycle.
- Halted: no new requests. A response already in flight is still pushed. FIFO contents still drain to decode. Only reset or redirect clears halted.
- Overflow and underflow are impossible by construction. An assertion flags push when count == DEPTH and pop when count == 0.
- Throughput: with single-cycle memory latency, at most one instruction every 2 cycles. DEPTH hides decode stalls only.

Test Plan:
1. Reset, then memory returns word = PC+0x100 one cycle after each grant, id_ready = 1 → imem_addr sequence 0,4,8,…; decode sees if_instr 0x100,0x104,… with if_pc_plus4 4,8,…, in order, none lost.
2. id_ready = 0 for 20 cycles → count saturates at 4, imem_req drops low; id_ready = 1 → four entries drain in order, fetch resumes at 0x10.
3. redirect with redirect_pc = 0x40 while a request to 0x8 is outstanding and 2 entries are queued → if_valid = 0 next cycle; the late 0x8 response is discarded; next imem_addr = 0x40; first head has if_pc_plus4 = 0x44.
4. redirect in the same cycle as imem_valid, plus a pop → response dropped, count = 0, drop = 0 afterwards, no imem_req in that cycle.
5. Memory returns 0xFC000000 at PC 0xC → halted = 1 after that push, no further imem_req, the halt word still reaches decode; then redirect to 0x0 → halted = 0, fetch restarts at 0x0.
6. reset asserted mid-stream with 3 entries queued and a request outstanding → next cycle if_valid = 0, halted = 0, imem_addr = RESET_PC; the stale response is ignored since outstanding = 0. Repeat with DEPTH = 2 and DEPTH = 8.
